// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and bitwise helper functions for
// the multi-round compression engine.
package sha256_pkg;

  typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise mod 2^32 addition of two packed eight-word vectors.
  function automatic logic [255:0] digest_add(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; state vectors pack a..h with a in [255:224].
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compression_mr.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, 16-word rolling schedule.
// Define SHA256_COMPRESSION_SHA224_EN to add the mode_224 port and SHA-224 output.
module sha256_compression_mr
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [255:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready
`ifdef SHA256_COMPRESSION_SHA224_EN
  ,
  input  logic         mode_224
`endif
);

  localparam int ROUND_CYCLES = 64 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_param
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t         state_reg;
  logic [255:0]   h_reg;
  logic [255:0]   work_reg;
  logic [31:0]    w_reg [16];
  logic [5:0]     cnt_reg;
  logic           last_reg;
  logic           first_reg;
  logic [255:0]   work_next;
  logic [255:0]   digest;
  logic [255:0]   out_word;
  logic [255:0]   iv_first;
  logic [255:0]   h_base;
  logic [31:0]    ext [16 + ROUNDS_PER_CYCLE];

  assign data_in_ready = (state_reg == LOAD) && en && !sync_rst;

  // Window extended by the R words this cycle shifts in; later words may
  // depend on earlier new ones, so the whole chain is evaluated in one block.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_reg[i];
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
      ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] + ssig0(ext[1 + j]) + ext[j];
  end

  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [255:0] st_in;
    logic [255:0] st_out;
    logic [5:0]   k_idx;
    assign k_idx = cnt_reg * 6'(ROUNDS_PER_CYCLE) + 6'(gi);
    if (gi == 0) begin : g_first
      assign st_in = work_reg;
    end else begin : g_chain
      assign st_in = g_round[gi-1].st_out;
    end
    sha256_round u_round (
      .state_in  (st_in),
      .k         (K[k_idx]),
      .w         (ext[gi]),
      .state_out (st_out)
    );
  end

  assign work_next = g_round[ROUNDS_PER_CYCLE-1].st_out;
  assign digest    = digest_add(h_reg, work_reg);
  assign h_base    = first_reg ? iv_first : h_reg;

`ifdef SHA256_COMPRESSION_SHA224_EN
  logic mode_reg;
  assign iv_first = mode_224 ? IV_224 : IV_256;
  assign out_word = mode_reg ? {digest[255:32], 32'h0} : digest;
`else
  assign iv_first = IV_256;
  assign out_word = digest;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= LOAD;
      h_reg          <= IV_256;
      work_reg       <= '0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      cnt_reg        <= '0;
      last_reg       <= 1'b0;
      first_reg      <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
`ifdef SHA256_COMPRESSION_SHA224_EN
      mode_reg       <= 1'b0;
`endif
    end else if (sync_rst) begin
      state_reg      <= LOAD;
      h_reg          <= IV_256;
      work_reg       <= '0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      cnt_reg        <= '0;
      last_reg       <= 1'b0;
      first_reg      <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
`ifdef SHA256_COMPRESSION_SHA224_EN
      mode_reg       <= 1'b0;
`endif
    end else if (en) begin
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
        data_out_last  <= 1'b0;
      end
      case (state_reg)
        LOAD: begin
          if (data_in_valid) begin
            for (int i = 0; i < 16; i++) w_reg[i] <= data_in[511 - 32*i -: 32];
            work_reg  <= h_base;
            h_reg     <= h_base;
            last_reg  <= data_in_last;
            first_reg <= data_in_last;
            cnt_reg   <= '0;
            state_reg <= ROUND;
`ifdef SHA256_COMPRESSION_SHA224_EN
            if (first_reg) mode_reg <= mode_224;
`endif
          end
        end
        ROUND: begin
          work_reg <= work_next;
          for (int i = 0; i < 16; i++) w_reg[i] <= ext[i + ROUNDS_PER_CYCLE];
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'(ROUND_CYCLES - 1)) state_reg <= FINAL;
        end
        FINAL: begin
          if (!last_reg) begin
            h_reg     <= digest;
            state_reg <= LOAD;
          end else if (!data_out_valid || data_out_ready) begin
            // Overrides the valid clear above when a digest replaces the one leaving.
            data_out       <= out_word;
            data_out_valid <= 1'b1;
            data_out_last  <= 1'b1;
            h_reg          <= IV_256;
            state_reg      <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compression_mr.sv
// Scoreboard bench for sha256_compression_mr: directed NIST vectors, latency,
// backpressure, enable freeze and synchronous reset; SHA-224 case under its macro.
`timescale 1ns/1ps
module tb_sha256_compression_mr;

  localparam int R      = 4;
  localparam int LAT    = 64 / R + 2;
  localparam int PERIOD = 10;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_2A  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] DIG_2   = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b1;
  logic         sync_rst = 1'b0;
  logic [511:0] data_in = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [255:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;
`ifdef SHA256_COMPRESSION_SHA224_EN
  localparam logic [255:0] DIG_224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
  logic         mode_224 = 1'b0;
`endif

  int             checks = 0;
  int             errors = 0;
  int             n_out  = 0;
  logic [255:0]   exp_q [$];
  time            xfer_t = 0;

  always #(PERIOD/2) clk = ~clk;

  sha256_compression_mr #(.ROUNDS_PER_CYCLE(R)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef SHA256_COMPRESSION_SHA224_EN
    ,
    .mode_224       (mode_224)
`endif
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Pops one expected digest per accepted output beat.
  task automatic monitor();
    logic [255:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (nrst && en && !sync_rst && data_out_valid && data_out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h required none", data_out);
        end else begin
          exp = exp_q.pop_front();
          $display("out %0d digest=%h last=%0b", n_out, data_out, data_out_last);
          chk("digest", data_out, exp);
          chk("out_last", 256'(data_out_last), 256'(1));
        end
      end
    end
  endtask

  task automatic send(input logic [511:0] blk, input logic last);
    int n = 0;
    @(negedge clk);
    data_in = blk;
    data_in_last = last;
    data_in_valid = 1'b1;
    #1;
    while (!data_in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("in_ready_timeout", 256'(data_in_ready), 256'(1));
    @(posedge clk);
    xfer_t = $time;
    $display("in  t=%0t word0=%h last=%0b", xfer_t, blk[511:480], last);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n = 0;
    int lat;
    while (!data_out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    lat = int'(($time + PERIOD/2 - xfer_t) / PERIOD);
    chk(name, 256'(lat), 256'(exp_lat));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk(name, 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    logic hold_bad;
    logic quiet_bad;
    logic en_bad;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_valid", 256'(data_out_valid), 256'(0));
    chk("rst_last", 256'(data_out_last), 256'(0));
    chk("rst_data", data_out, 256'(0));
    chk("rst_ready", 256'(data_in_ready), 256'(1));

    // Single-block "abc"
    exp_q.push_back(DIG_ABC);
    send(BLK_ABC, 1'b1);
    wait_valid("abc_latency", LAT);
    drain("abc_drain");

    // Two-block message, nothing emitted after the first block
    exp_q.push_back(DIG_2);
    send(BLK_2A, 1'b0);
    while (!data_in_ready) @(negedge clk);
    chk("blk1_no_output", 256'(data_out_valid), 256'(0));
    send(BLK_2B, 1'b1);
    wait_valid("two_blk_latency", LAT);
    drain("two_blk_drain");

    // Backpressure across two back-to-back messages
    @(negedge clk);
    data_out_ready = 1'b0;
    exp_q.push_back(DIG_ABC);
    exp_q.push_back(DIG_ABC);
    send(BLK_ABC, 1'b1);
    wait_valid("bp_latency", LAT);
    send(BLK_ABC, 1'b1);
    hold_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!data_out_valid || data_out !== DIG_ABC) hold_bad = 1'b1;
    end
    #1;
    chk("bp_hold", 256'(hold_bad), 256'(0));
    chk("bp_stall_final", 256'(data_in_ready), 256'(0));
    chk("bp_pending", 256'(exp_q.size()), 256'(2));
    @(negedge clk);
    data_out_ready = 1'b1;
    drain("bp_drain");

    // Enable held low for 10 cycles mid-ROUND
    exp_q.push_back(DIG_ABC);
    send(BLK_ABC, 1'b1);
    repeat (5) @(negedge clk);
    en = 1'b0;
    en_bad = 1'b0;
    repeat (10) begin
      #1;
      if (data_in_ready !== 1'b0) en_bad = 1'b1;
      @(negedge clk);
    end
    en = 1'b1;
    chk("en_ready_low", 256'(en_bad), 256'(0));
    wait_valid("en_latency", LAT + 10);
    drain("en_drain");

    // Synchronous reset in the middle of block 1
    send(BLK_2A, 1'b0);
    repeat (7) @(negedge clk);
    sync_rst = 1'b1;
    #1;
    chk("srst_ready", 256'(data_in_ready), 256'(0));
    @(negedge clk);
    sync_rst = 1'b0;
    #1;
    chk("srst_valid", 256'(data_out_valid), 256'(0));
    chk("srst_data", data_out, 256'(0));
    chk("srst_load", 256'(data_in_ready), 256'(1));
    quiet_bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (data_out_valid) quiet_bad = 1'b1;
    end
    chk("srst_quiet", 256'(quiet_bad), 256'(0));
    exp_q.push_back(DIG_ABC);
    send(BLK_ABC, 1'b1);
    wait_valid("srst_abc_latency", LAT);
    drain("srst_drain");

`ifdef SHA256_COMPRESSION_SHA224_EN
    mode_224 = 1'b1;
    exp_q.push_back(DIG_224);
    send(BLK_ABC, 1'b1);
    mode_224 = 1'b0;
    wait_valid("sha224_latency", LAT);
    drain("sha224_drain");
    exp_q.push_back(DIG_ABC);
    send(BLK_ABC, 1'b1);
    wait_valid("sha256_after_224_latency", LAT);
    drain("sha256_after_224_drain");
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
